// File: rtl/ysyx22041405_elastic_stage_if.sv
// ============================================================================
// ysyx22041405_elastic_stage_if : valid/ready/data bundle between pipe stages
// Rev 1.0
// ============================================================================
`default_nettype none

interface ysyx22041405_elastic_stage_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/ysyx22041405_elastic_stage.sv
// ============================================================================
// ysyx22041405_elastic_stage : valid/ready elastic FIFO stage with flush and
// saturating stall counter.  Rev 1.0
// ============================================================================
`default_nettype none

module ysyx22041405_elastic_stage #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 2,
  parameter int STALL_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  ysyx22041405_elastic_stage_if.slave  s_in,
  ysyx22041405_elastic_stage_if.master m_out,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [STALL_W-1:0]           o_stall_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] c_LAST  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [STALL_W-1:0] r_stall;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // in_ready depends on stored occupancy only, never on out_ready
  assign w_in_ready  = (r_count < c_DEPTH);
  assign w_out_valid = (r_count != '0);
  assign w_push      = s_in.valid & w_in_ready;
  assign w_pop       = w_out_valid & m_out.ready;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == c_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= f_next(r_wptr);
      if (w_pop)  r_rptr <= f_next(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= s_in.data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (s_in.valid && !w_in_ready && (r_stall != '1)) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign s_in.ready  = w_in_ready;
  assign m_out.valid = w_out_valid;
  assign m_out.data  = w_out_valid ? r_mem[r_rptr] : '0;
  assign o_count     = r_count;
  assign o_stall_cnt = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_ysyx22041405_elastic_stage.sv
// ============================================================================
// tb_ysyx22041405_elastic_stage : scoreboard bench over DEPTH 2/3/1 instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ysyx22041405_elastic_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sbq [$];
  logic [63:0] exp_d;

  // A: DEPTH 2, B: DEPTH 3, C: DEPTH 1 with a 4-bit stall counter
  ysyx22041405_elastic_stage_if #(.WIDTH(64)) a_in ();
  ysyx22041405_elastic_stage_if #(.WIDTH(64)) a_out ();
  ysyx22041405_elastic_stage_if #(.WIDTH(64)) b_in ();
  ysyx22041405_elastic_stage_if #(.WIDTH(64)) b_out ();
  ysyx22041405_elastic_stage_if #(.WIDTH(64)) c_in ();
  ysyx22041405_elastic_stage_if #(.WIDTH(64)) c_out ();

  logic        a_flush, b_flush, c_flush;
  logic [1:0]  a_cnt, b_cnt;
  logic [0:0]  c_cnt;
  logic [15:0] a_st, b_st;
  logic [3:0]  c_st;

  ysyx22041405_elastic_stage #(.WIDTH(64), .DEPTH(2), .STALL_W(16)) u_a (
    .clk(clk), .rst(rst), .i_flush(a_flush), .s_in(a_in), .m_out(a_out),
    .o_count(a_cnt), .o_stall_cnt(a_st));
  ysyx22041405_elastic_stage #(.WIDTH(64), .DEPTH(3), .STALL_W(16)) u_b (
    .clk(clk), .rst(rst), .i_flush(b_flush), .s_in(b_in), .m_out(b_out),
    .o_count(b_cnt), .o_stall_cnt(b_st));
  ysyx22041405_elastic_stage #(.WIDTH(64), .DEPTH(1), .STALL_W(4)) u_c (
    .clk(clk), .rst(rst), .i_flush(c_flush), .s_in(c_in), .m_out(c_out),
    .o_count(c_cnt), .o_stall_cnt(c_st));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic [63:0] d, input logic r, input logic f);
    a_in.valid = v; a_in.data = d; a_out.ready = r; a_flush = f;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [63:0] d, input logic r, input logic f);
    b_in.valid = v; b_in.data = d; b_out.ready = r; b_flush = f;
    #1;
  endtask

  task automatic drive_c(input logic v, input logic [63:0] d, input logic r, input logic f);
    c_in.valid = v; c_in.data = d; c_out.ready = r; c_flush = f;
    #1;
  endtask

  task automatic do_reset();
    drive_a(1'b0, 64'd0, 1'b0, 1'b0);
    drive_b(1'b0, 64'd0, 1'b0, 1'b0);
    drive_c(1'b0, 64'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    sbq.delete();
  endtask

  task automatic test_reset();
    drive_a(1'b0, 64'd0, 1'b0, 1'b0);
    drive_b(1'b0, 64'd0, 1'b0, 1'b0);
    drive_c(1'b0, 64'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) rst = 1'b1;
      #1;
      n_checks++;
      if (a_out.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, a_out.valid); end
      n_checks++;
      if (a_out.data !== 64'd0) begin n_fail++; $display("FAIL reset_out_data[%0d]: got %0h expected 0", k, a_out.data); end
      n_checks++;
      if (a_in.ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, a_in.ready); end
      n_checks++;
      if (a_cnt !== 2'd0 || c_cnt !== 1'd0) begin n_fail++; $display("FAIL reset_count[%0d]: got %0d/%0d expected 0/0", k, a_cnt, c_cnt); end
      n_checks++;
      if (a_st !== 16'd0) begin n_fail++; $display("FAIL reset_stall[%0d]: got %0d expected 0", k, a_st); end
      tick();
    end
  endtask

  task automatic test_streaming();
    int   i;
    int   pops;
    logic v;
    do_reset();
    i = 1; pops = 0;
    for (int k = 0; k < 12; k++) begin
      v = (i <= 8);
      drive_a(v, 64'(i), 1'b1, 1'b0);
      if (v) begin
        n_checks++;
        if (a_in.ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", k, a_in.ready); end
      end
      if (k >= 1 && k <= 8) begin
        n_checks++;
        if (a_out.valid !== 1'b1) begin n_fail++; $display("FAIL stream_out_valid[%0d]: got %b expected 1", k, a_out.valid); end
      end
      if (a_out.valid) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL stream_extra[%0d]: got %0h expected no output", k, a_out.data);
        end else begin
          exp_d = sbq.pop_front();
          pops++;
          if (a_out.data !== exp_d) begin n_fail++; $display("FAIL stream_data[%0d]: got %0h expected %0h", k, a_out.data, exp_d); end
        end
      end
      if (v && a_in.ready) begin sbq.push_back(64'(i)); i++; end
      tick();
    end
    n_checks++;
    if (pops != 8) begin n_fail++; $display("FAIL stream_pops: got %0d expected 8", pops); end
    n_checks++;
    if (a_st !== 16'd0) begin n_fail++; $display("FAIL stream_stall: got %0d expected 0", a_st); end
  endtask

  task automatic test_backpressure();
    logic dpend;
    int   pops;
    do_reset();
    dpend = 1'b1; pops = 0;
    for (int k = 0; k < 3; k++) begin
      drive_b(1'b1, 64'(10 + k), 1'b0, 1'b0);
      n_checks++;
      if (b_in.ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready[%0d]: got %b expected 1", k, b_in.ready); end
      if (b_in.ready) sbq.push_back(64'(10 + k));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive_b(1'b1, 64'hD, 1'b0, 1'b0);
      n_checks++;
      if (b_in.ready !== 1'b0) begin n_fail++; $display("FAIL bp_block_ready[%0d]: got %b expected 0", k, b_in.ready); end
      if (b_in.ready && dpend) begin sbq.push_back(64'hD); dpend = 1'b0; end
      tick();
    end
    #1;
    n_checks++;
    if (b_cnt !== 2'd3) begin n_fail++; $display("FAIL bp_count: got %0d expected 3", b_cnt); end
    n_checks++;
    if (b_in.ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", b_in.ready); end
    n_checks++;
    if (b_st !== 16'd4) begin n_fail++; $display("FAIL bp_stall: got %0d expected 4", b_st); end
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      drive_b(dpend, 64'hD, 1'b1, 1'b0);
      if (b_out.valid) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL bp_extra[%0d]: got %0h expected no output", k, b_out.data);
        end else begin
          exp_d = sbq.pop_front();
          pops++;
          if (b_out.data !== exp_d) begin n_fail++; $display("FAIL bp_data[%0d]: got %0h expected %0h", k, b_out.data, exp_d); end
        end
      end
      if (dpend && b_in.ready) begin sbq.push_back(64'hD); dpend = 1'b0; end
      tick();
    end
    n_checks++;
    if (pops != 4 || sbq.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pops expected 4", pops); end
  endtask

  task automatic test_depth1();
    int   i;
    int   pops;
    logic v;
    do_reset();
    i = 0; pops = 0;
    for (int k = 0; k < 9; k++) begin
      v = (i < 3);
      drive_c(v, 64'(16 + i), 1'b1, 1'b0);
      if (k < 6) begin
        n_checks++;
        if (c_in.ready !== ((k % 2) == 0)) begin n_fail++; $display("FAIL d1_in_ready[%0d]: got %b expected %b", k, c_in.ready, (k % 2) == 0); end
      end
      if (c_out.valid) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL d1_extra[%0d]: got %0h expected no output", k, c_out.data);
        end else begin
          exp_d = sbq.pop_front();
          pops++;
          if (c_out.data !== exp_d) begin n_fail++; $display("FAIL d1_data[%0d]: got %0h expected %0h", k, c_out.data, exp_d); end
        end
      end
      if (v && c_in.ready) begin sbq.push_back(64'(16 + i)); i++; end
      tick();
    end
    n_checks++;
    if (pops != 3) begin n_fail++; $display("FAIL d1_pops: got %0d expected 3", pops); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_b(1'b1, 64'(4 + k), 1'b0, 1'b0);
      if (b_in.ready) sbq.push_back(64'(4 + k));
      tick();
    end
    drive_b(1'b1, 64'h7, 1'b0, 1'b0);
    tick();
    drive_b(1'b0, 64'd0, 1'b1, 1'b0);
    n_checks++;
    exp_d = (sbq.size() != 0) ? sbq.pop_front() : 64'hDEAD;
    if (b_out.data !== exp_d) begin n_fail++; $display("FAIL flush_pre_pop: got %0h expected %0h", b_out.data, exp_d); end
    tick();
    n_checks++;
    if (b_cnt !== 2'd2 || b_st !== 16'd1) begin n_fail++; $display("FAIL flush_pre_state: got count %0d stall %0d expected 2 1", b_cnt, b_st); end
    drive_b(1'b1, 64'h7, 1'b1, 1'b1);
    tick();
    sbq.delete();
    drive_b(1'b0, 64'd0, 1'b0, 1'b0);
    n_checks++;
    if (b_cnt !== 2'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", b_cnt); end
    n_checks++;
    if (b_out.valid !== 1'b0 || b_out.data !== 64'd0) begin n_fail++; $display("FAIL flush_out: got valid %b data %0h expected 0 0", b_out.valid, b_out.data); end
    n_checks++;
    if (b_in.ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", b_in.ready); end
    n_checks++;
    if (b_st !== 16'd1) begin n_fail++; $display("FAIL flush_stall: got %0d expected 1", b_st); end
    drive_b(1'b1, 64'h8, 1'b1, 1'b0);
    tick();
    drive_b(1'b0, 64'd0, 1'b1, 1'b0);
    n_checks++;
    if (b_out.valid !== 1'b1 || b_out.data !== 64'h8) begin n_fail++; $display("FAIL flush_post_push: got valid %b data %0h expected 1 8", b_out.valid, b_out.data); end
    tick();
    n_checks++;
    if (b_cnt !== 2'd0) begin n_fail++; $display("FAIL flush_post_count: got %0d expected 0", b_cnt); end
  endtask

  task automatic test_wrap();
    int   i;
    int   pops;
    logic v;
    logic r;
    do_reset();
    i = 0; pops = 0;
    for (int k = 0; k < 32; k++) begin
      v = (k < 24) && ((k % 5) != 4);
      r = (k >= 24) || ((k % 3) != 0);
      drive_b(v, 64'h100 + 64'(i), r, 1'b0);
      if (b_out.valid && r) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL wrap_extra[%0d]: got %0h expected no output", k, b_out.data);
        end else begin
          exp_d = sbq.pop_front();
          pops++;
          if (b_out.data !== exp_d) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", k, b_out.data, exp_d); end
        end
      end
      if (v && b_in.ready) begin sbq.push_back(64'h100 + 64'(i)); i++; end
      tick();
    end
    n_checks++;
    if (pops != i || sbq.size() != 0 || i < 10) begin n_fail++; $display("FAIL wrap_balance: got %0d pops expected %0d", pops, i); end
  endtask

  task automatic test_saturate();
    do_reset();
    drive_c(1'b1, 64'h55, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 20; k++) begin
      drive_c(1'b1, 64'h66, 1'b0, 1'b0);
      tick();
      if (k == 10) begin
        n_checks++;
        if (c_st !== 4'd10) begin n_fail++; $display("FAIL sat_mid: got %0d expected 10", c_st); end
      end
    end
    n_checks++;
    if (c_st !== 4'd15) begin n_fail++; $display("FAIL sat_value: got %0d expected 15", c_st); end
    for (int k = 0; k < 3; k++) tick();
    n_checks++;
    if (c_st !== 4'd15 || c_cnt !== 1'd1) begin n_fail++; $display("FAIL sat_hold: got stall %0d count %0d expected 15 1", c_st, c_cnt); end
    drive_c(1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive_a(1'b1, 64'(k + 1), 1'b0, 1'b0);
      tick();
    end
    drive_a(1'b0, 64'd0, 1'b0, 1'b0);
    n_checks++;
    if (a_cnt !== 2'd2 || a_out.valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got count %0d valid %b expected 2 1", a_cnt, a_out.valid); end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (a_out.valid !== 1'b0 || a_out.data !== 64'd0) begin n_fail++; $display("FAIL arst_out: got valid %b data %0h expected 0 0", a_out.valid, a_out.data); end
    n_checks++;
    if (a_cnt !== 2'd0 || a_in.ready !== 1'b1) begin n_fail++; $display("FAIL arst_state: got count %0d ready %b expected 0 1", a_cnt, a_in.ready); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_depth1();
    test_flush();
    test_wrap();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
